dict_find: RTL and testbench

- Read-side counterpart of the dictionary builder.
- Scans one blank/NUL-delimited token from the TIB in byte memory, then walks the linked word list from `ctx` toward NULL, comparing names.
- On a hit it returns the entry's pfa and opcode byte.
- Sits beside the outer interpreter as an 8-bit memory bus master with one byte read per cycle.

---
 rtl/dict_find.sv | 262 ++++++++++++++++++++++++++
 tb/tb_dict_find.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_find.sv
// ---------------------------------------------------------------------------
// dict_find
//
// Read-side dictionary search. On a start pulse it measures one blank/NUL
// delimited token in the TIB, then walks the linked word list from the head
// entry toward the end-of-list link, comparing each entry's name with the
// token. On a hit it returns the entry's parameter field address and the
// opcode byte stored there. It masters an 8-bit byte memory with one read
// per cycle; read data arrives the cycle after the address is presented.
//
// Entry layout at lfa: link lo, link hi, len, name[len], opcode.
// The parameter field address is lfa+3+len.
//
// Optional build macro:
//   FIND_NOCASE_EN - name compare folds ASCII 'a'..'z' to upper case.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   en       in   start pulse, sampled only while idle
//   ctx      in   list head (latest entry address), latched on start
//   tib_a    in   token start address, latched on start
//   mem_re   out  read strobe
//   mem_a    out  read address
//   mem_vo   in   read data for the address presented last cycle
//   bsy      out  search in progress
//   done     out  one-cycle pulse, results valid
//   hit      out  match found (held)
//   pfa      out  parameter field address of the hit (held, 0 on miss)
//   op       out  opcode byte at pfa (held, 0 on miss)
//   tok_len  out  measured token length (held)
//   nxt      out  tib_a + tok_len, the delimiter position (held)
// ---------------------------------------------------------------------------
module dict_find #(
   parameter int          ASZ      = 17,
   parameter int          DSZ      = 8,
   parameter logic [15:0] NULL_LFA = 16'hffff,
   parameter int          MAX_LEN  = 31
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [ASZ-1:0] ctx,
   input  logic [ASZ-1:0] tib_a,
   output logic           mem_re,
   output logic [ASZ-1:0] mem_a,
   input  logic [DSZ-1:0] mem_vo,
   output logic           bsy,
   output logic           done,
   output logic           hit,
   output logic [ASZ-1:0] pfa,
   output logic [DSZ-1:0] op,
   output logic [5:0]     tok_len,
   output logic [ASZ-1:0] nxt
);

   typedef enum logic [3:0] {
      S_IDLE, S_TLEN, S_LNK0, S_LNK1, S_NLEN, S_CMPD, S_CMPT, S_OPC, S_DONE
   } state_t;

   state_t         r_state, w_stateNext;
   logic [ASZ-1:0] r_lfa;
   logic [ASZ-1:0] r_tp;
   logic [5:0]     r_tlen;
   logic [5:0]     r_idx;
   logic [15:0]    r_link;
   logic [DSZ-1:0] r_dbyte;
   logic           r_hit;
   logic [ASZ-1:0] r_pfa;
   logic [DSZ-1:0] r_op;
   logic [5:0]     r_tokLen;
   logic [ASZ-1:0] r_nxt;

   logic           w_memRe;
   logic [ASZ-1:0] w_memA;
   logic           w_tokEnd;
   logic           w_lenMatch;
   logic           w_lastIdx;
   logic           w_cmpEq;
   logic           w_linkNull;
   logic           w_lfaNull;
   logic [ASZ-1:0] w_nameBase;
   logic [ASZ-1:0] w_pfaCalc;

`ifdef FIND_NOCASE_EN
   function automatic logic [DSZ-1:0] foldCase(input logic [DSZ-1:0] b);
      if (b >= DSZ'(8'h61) && b <= DSZ'(8'h7a))
         return b - DSZ'(8'h20);
      return b;
   endfunction
   assign w_cmpEq = (foldCase(mem_vo) == foldCase(r_dbyte));
`else
   assign w_cmpEq = (mem_vo == r_dbyte);
`endif

   // The length limit ends the token even if the byte is not a delimiter,
   // which truncates over-long tokens.
   assign w_tokEnd   = (mem_vo == '0) || (mem_vo == DSZ'(8'h20)) ||
                       (r_tlen == 6'(MAX_LEN));
   assign w_lenMatch = (mem_vo == DSZ'(r_tlen));
   assign w_lastIdx  = (r_idx == r_tlen - 6'd1);
   assign w_linkNull = (r_link == NULL_LFA);
   assign w_lfaNull  = (r_lfa == ASZ'(NULL_LFA));
   assign w_nameBase = r_lfa + ASZ'(3);
   assign w_pfaCalc  = w_nameBase + ASZ'(r_tlen);

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_stateNext;
   end

   // Next-state and read-address decode. Each state presents the address
   // whose data the following state consumes. Leaving an entry (length or
   // byte mismatch) either finishes on the end-of-list link or jumps
   // straight to the next entry's link read without a separate cycle.
   always_comb begin
      w_stateNext = r_state;
      w_memRe     = 1'b0;
      w_memA      = '0;
      case (r_state)
         S_IDLE: begin
            if (en) begin
               w_stateNext = S_TLEN;
               w_memRe     = 1'b1;
               w_memA      = tib_a;
            end
         end
         S_TLEN: begin
            if (w_tokEnd) begin
               if (r_tlen == 6'd0 || w_lfaNull) begin
                  w_stateNext = S_DONE;
               end else begin
                  w_stateNext = S_LNK0;
                  w_memRe     = 1'b1;
                  w_memA      = r_lfa;
               end
            end else begin
               w_memRe = 1'b1;
               w_memA  = r_tp + ASZ'(r_tlen + 6'd1);
            end
         end
         S_LNK0: begin
            w_stateNext = S_LNK1;
            w_memRe     = 1'b1;
            w_memA      = r_lfa + ASZ'(1);
         end
         S_LNK1: begin
            w_stateNext = S_NLEN;
            w_memRe     = 1'b1;
            w_memA      = r_lfa + ASZ'(2);
         end
         S_NLEN: begin
            if (w_lenMatch) begin
               w_stateNext = S_CMPD;
               w_memRe     = 1'b1;
               w_memA      = w_nameBase;
            end else if (w_linkNull) begin
               w_stateNext = S_DONE;
            end else begin
               w_stateNext = S_LNK0;
               w_memRe     = 1'b1;
               w_memA      = ASZ'(r_link);
            end
         end
         S_CMPD: begin
            w_stateNext = S_CMPT;
            w_memRe     = 1'b1;
            w_memA      = r_tp + ASZ'(r_idx);
         end
         S_CMPT: begin
            if (!w_cmpEq) begin
               if (w_linkNull) begin
                  w_stateNext = S_DONE;
               end else begin
                  w_stateNext = S_LNK0;
                  w_memRe     = 1'b1;
                  w_memA      = ASZ'(r_link);
               end
            end else if (w_lastIdx) begin
               w_stateNext = S_OPC;
               w_memRe     = 1'b1;
               w_memA      = w_pfaCalc;
            end else begin
               w_stateNext = S_CMPD;
               w_memRe     = 1'b1;
               w_memA      = w_nameBase + ASZ'(r_idx + 6'd1);
            end
         end
         S_OPC:   w_stateNext = S_DONE;
         S_DONE:  w_stateNext = S_IDLE;
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Datapath: search context, link assembly and held results. Results are
   // written on the edge into DONE so they are valid while done is high;
   // hit/pfa/op are cleared on start so a miss reports zeros.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfa    <= '0;
         r_tp     <= '0;
         r_tlen   <= '0;
         r_idx    <= '0;
         r_link   <= '0;
         r_dbyte  <= '0;
         r_hit    <= 1'b0;
         r_pfa    <= '0;
         r_op     <= '0;
         r_tokLen <= '0;
         r_nxt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_lfa  <= ctx;
                  r_tp   <= tib_a;
                  r_tlen <= '0;
                  r_hit  <= 1'b0;
                  r_pfa  <= '0;
                  r_op   <= '0;
               end
            end
            S_TLEN: if (!w_tokEnd) r_tlen <= r_tlen + 6'd1;
            S_LNK0: r_link[7:0]  <= mem_vo[7:0];
            S_LNK1: r_link[15:8] <= mem_vo[7:0];
            S_NLEN: begin
               if (w_lenMatch) r_idx <= '0;
               else            r_lfa <= ASZ'(r_link);
            end
            S_CMPD: r_dbyte <= mem_vo;
            S_CMPT: begin
               if (!w_cmpEq)       r_lfa <= ASZ'(r_link);
               else if (!w_lastIdx) r_idx <= r_idx + 6'd1;
            end
            S_OPC: begin
               r_op  <= mem_vo;
               r_pfa <= w_pfaCalc;
               r_hit <= 1'b1;
            end
            default: ;
         endcase
         if (w_stateNext == S_DONE && r_state != S_DONE) begin
            r_tokLen <= r_tlen;
            r_nxt    <= r_tp + ASZ'(r_tlen);
         end
      end
   end

   assign mem_re  = w_memRe & ~rst;
   assign mem_a   = rst ? '0 : w_memA;
   assign bsy     = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done    = (r_state == S_DONE);
   assign hit     = r_hit;
   assign pfa     = r_pfa;
   assign op      = r_op;
   assign tok_len = r_tokLen;
   assign nxt     = r_nxt;

endmodule

// File: tb/tb_dict_find.sv
// ---------------------------------------------------------------------------
// tb_dict_find
//
// Directed bench for dict_find. A byte memory holds a six-word dictionary
// and several TIB strings. A list-walking reference model predicts each
// search's results and its cycle count; a compare process checks the DUT
// every cycle a search is outstanding, and hand-derived literals pin the
// key cases.
// ---------------------------------------------------------------------------
module tb_dict_find;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [16:0] ctx;
   logic [16:0] tib_a;
   logic        mem_re;
   logic [16:0] mem_a;
   logic [7:0]  mem_vo;
   logic        bsy;
   logic        done;
   logic        hit;
   logic [16:0] pfa;
   logic [7:0]  op;
   logic [5:0]  tok_len;
   logic [16:0] nxt;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:131071];

   logic        expHit;
   logic [16:0] expPfa;
   logic [16:0] expNxt;
   logic [7:0]  expOp;
   int          expLen;
   int          expCyc;
   bit          noDict;
   bit          pending = 1'b0;
   int          cyc;
   int          lastCyc;
   int          dictReads;

   // Free-running clock.
   always #5 clk = ~clk;

   dict_find dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .ctx     (ctx),
      .tib_a   (tib_a),
      .mem_re  (mem_re),
      .mem_a   (mem_a),
      .mem_vo  (mem_vo),
      .bsy     (bsy),
      .done    (done),
      .hit     (hit),
      .pfa     (pfa),
      .op      (op),
      .tok_len (tok_len),
      .nxt     (nxt)
   );

   // Synchronous byte memory: data for a strobed address appears next cycle.
   always @(posedge clk) begin
      if (mem_re) mem_vo <= mem[mem_a];
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic logic [7:0] foldCase(input logic [7:0] b);
`ifdef FIND_NOCASE_EN
      if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
`endif
      return b;
   endfunction

   // Reference model: read the token, walk the list, and tally cycles as
   // token scan (len+1), 3 per visited entry, 2 per compared name byte,
   // 1 for the opcode read on a hit, and 1 for the done cycle.
   task automatic modelFind(input logic [16:0] c, input logic [16:0] t);
      int          n;
      logic [16:0] lfa;
      logic [16:0] a;
      bit          match;
      n = 0;
      a = t;
      while (n < 31 && mem[a] != 8'h00 && mem[a] != 8'h20) begin
         n++;
         a = t + 17'(n);
      end
      expLen = n;
      expNxt = t + 17'(n);
      expCyc = n + 1;
      expHit = 1'b0;
      expPfa = '0;
      expOp  = '0;
      if (n != 0) begin
         lfa = c;
         for (int guard = 0; guard < 1000 && lfa != 17'h0ffff; guard++) begin
            expCyc += 3;
            if (int'(mem[lfa + 17'd2]) == n) begin
               match = 1'b1;
               for (int k = 0; k < n; k++) begin
                  expCyc += 2;
                  if (foldCase(mem[lfa + 17'd3 + 17'(k)]) !=
                      foldCase(mem[t + 17'(k)])) begin
                     match = 1'b0;
                     break;
                  end
               end
               if (match) begin
                  expCyc += 1;
                  expHit = 1'b1;
                  expPfa = lfa + 17'd3 + 17'(n);
                  expOp  = mem[expPfa];
                  break;
               end
            end
            lfa = {1'b0, mem[lfa + 17'd1], mem[lfa]};
         end
      end
      expCyc += 1;
   endtask

   task automatic putEntry(input logic [16:0] addr, input logic [15:0] link,
                           input string name, input logic [7:0] opc);
      mem[addr]        = link[7:0];
      mem[addr + 17'd1] = link[15:8];
      mem[addr + 17'd2] = 8'(name.len());
      for (int i = 0; i < name.len(); i++)
         mem[addr + 17'd3 + 17'(i)] = name[i];
      mem[addr + 17'd3 + 17'(name.len())] = opc;
   endtask

   task automatic putString(input logic [16:0] addr, input string s);
      for (int i = 0; i < s.len(); i++)
         mem[addr + 17'(i)] = s[i];
      mem[addr + 17'(s.len())] = 8'h00;
   endtask

   // Compare process: while a search is outstanding, bsy must stay high
   // until done; on done every result and the cycle count must match the
   // model. Outside a search done must stay low.
   always @(negedge clk) begin
      if (pending) begin
         cyc++;
         if (mem_re && mem_a >= 17'h100) dictReads++;
         if (done) begin
            lastCyc = cyc;
            checkOutput("hit", 32'(hit), 32'(expHit));
            checkOutput("pfa", 32'(pfa), 32'(expPfa));
            checkOutput("op", 32'(op), 32'(expOp));
            checkOutput("tok_len", 32'(tok_len), 32'(expLen));
            checkOutput("nxt", 32'(nxt), 32'(expNxt));
            checkOutput("cycles", 32'(cyc), 32'(expCyc));
            checkOutput("bsyAtDone", 32'(bsy), 32'd0);
            if (noDict) checkOutput("dictReads", 32'(dictReads), 32'd0);
            pending = 1'b0;
         end else begin
            checkOutput("bsyBusy", 32'(bsy), 32'd1);
         end
      end else if (!rst) begin
         checkOutput("strayDone", 32'(done), 32'd0);
      end
   end

   // Start one search and wait (bounded) for the compare process to see done.
   task automatic applyStimulus(input logic [16:0] c, input logic [16:0] t,
                                input bit nd);
      modelFind(c, t);
      noDict    = nd;
      dictReads = 0;
      @(posedge clk); #2;
      ctx   = c;
      tib_a = t;
      en    = 1'b1;
      @(posedge clk); #2;
      en      = 1'b0;
      cyc     = 0;
      pending = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if (!pending) break;
         @(posedge clk);
      end
      if (pending) begin
         checkOutput("timeout", 32'd1, 32'd0);
         pending = 1'b0;
      end
      #2;
   endtask

   initial begin
      rst   = 1'b1;
      en    = 1'b0;
      ctx   = '0;
      tib_a = '0;
      for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
      putString(17'h000, "dup swap +");
      putString(17'h010, "rot");
      putString(17'h020, "DUP");
      for (int i = 0; i < 40; i++) mem[17'h040 + 17'(i)] = 8'h61;
      putEntry(17'h100, 16'hffff, "nop",  8'ha1);
      putEntry(17'h107, 16'h0100, "dup",  8'ha2);
      putEntry(17'h10e, 16'h0107, "drop", 8'ha3);
      putEntry(17'h116, 16'h010e, "swap", 8'ha4);
      putEntry(17'h11e, 16'h0116, "+",    8'ha5);
      putEntry(17'h123, 16'h011e, "-",    8'ha6);

      // Reset values while reset is held.
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rstBsy", 32'(bsy), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstHit", 32'(hit), 32'd0);
      checkOutput("rstMemRe", 32'(mem_re), 32'd0);
      checkOutput("rstMemA", 32'(mem_a), 32'd0);
      checkOutput("rstPfa", 32'(pfa), 32'd0);
      checkOutput("rstOp", 32'(op), 32'd0);
      checkOutput("rstTokLen", 32'(tok_len), 32'd0);
      checkOutput("rstNxt", 32'(nxt), 32'd0);
      rst = 1'b0;

      // Hits on the first, second and third TIB tokens.
      applyStimulus(17'h123, 17'h000, 1'b0);
      checkOutput("dupHit", 32'(hit), 32'd1);
      checkOutput("dupPfa", 32'(pfa), 32'h10d);
      checkOutput("dupOp", 32'(op), 32'ha2);
      checkOutput("dupLen", 32'(tok_len), 32'd3);
      checkOutput("dupNxt", 32'(nxt), 32'd3);

      applyStimulus(17'h123, 17'h004, 1'b0);
      checkOutput("swapPfa", 32'(pfa), 32'h11d);
      checkOutput("swapNxt", 32'(nxt), 32'd8);
      checkOutput("swapOp", 32'(op), 32'ha4);

      applyStimulus(17'h123, 17'h009, 1'b0);
      checkOutput("plusPfa", 32'(pfa), 32'h122);
      checkOutput("plusLen", 32'(tok_len), 32'd1);
      checkOutput("plusNxt", 32'(nxt), 32'd10);

      // Full walk with no match.
      applyStimulus(17'h123, 17'h010, 1'b0);
      checkOutput("rotHit", 32'(hit), 32'd0);
      checkOutput("rotPfa", 32'(pfa), 32'd0);
      checkOutput("rotCycles", 32'(lastCyc), 32'd27);

      // Empty list: only the token scan runs.
      applyStimulus(17'h0ffff, 17'h000, 1'b1);
      checkOutput("nullHit", 32'(hit), 32'd0);
      checkOutput("nullCycles", 32'(lastCyc), 32'd5);

      // Token starting with a blank.
      applyStimulus(17'h123, 17'h003, 1'b1);
      checkOutput("blankLen", 32'(tok_len), 32'd0);
      checkOutput("blankCycles", 32'(lastCyc), 32'd2);

      // Over-long token is truncated to 31.
      applyStimulus(17'h123, 17'h040, 1'b0);
      checkOutput("longLen", 32'(tok_len), 32'd31);
      checkOutput("longNxt", 32'(nxt), 32'h05f);

      // Reset in the CMPT cycle of the "dup" entry (cycle 21 after start).
      @(posedge clk); #2;
      ctx   = 17'h123;
      tib_a = 17'h000;
      en    = 1'b1;
      @(posedge clk); #2;
      en = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      checkOutput("preRstAddr", 32'(mem_a), 32'h10b);
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      checkOutput("abortBsy", 32'(bsy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortMemRe", 32'(mem_re), 32'd0);
      checkOutput("abortHit", 32'(hit), 32'd0);
      checkOutput("abortPfa", 32'(pfa), 32'd0);
      repeat (5) @(posedge clk);
      applyStimulus(17'h123, 17'h000, 1'b0);
      checkOutput("afterRstPfa", 32'(pfa), 32'h10d);

      // Upper-case token: matches only with case folding built in.
      applyStimulus(17'h123, 17'h020, 1'b0);
`ifdef FIND_NOCASE_EN
      checkOutput("upperHit", 32'(hit), 32'd1);
      checkOutput("upperPfa", 32'(pfa), 32'h10d);
`else
      checkOutput("upperHit", 32'(hit), 32'd0);
      checkOutput("upperPfa", 32'(pfa), 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
